// File: rtl/tree_adder.sv
// tree_adder: balanced, fully pipelined signed adder tree summing NUM_INPUTS operands in LEVELS clocks.
// Ports:
//   clk       rising-edge clock for all registers
//   rst       synchronous active-high reset, clears every pipeline register
//   numbers   packed operands, operand k at [k*INPUT_WIDTH +: INPUT_WIDTH], signed
//   in_valid  (TREE_ADDER_VALID_EN only) marks numbers as a real vector
//   out_valid (TREE_ADDER_VALID_EN only) total_sum holds the sum of a valid vector
//   total_sum signed sum of all operands, straight from the last register level
// Optional feature macro: TREE_ADDER_VALID_EN adds the valid tracking ports.

module int_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH:0]   sum
);
    logic [WIDTH:0] sum_d, sum_q;
    always_comb sum_d = {a[WIDTH-1], a} + {b[WIDTH-1], b};
    always_ff @(posedge clk) begin
        if (rst) sum_q <= '0;
        else     sum_q <= sum_d;
    end
    assign sum = sum_q;
endmodule

module tree_adder #(
    parameter  int INPUT_WIDTH = 8,
    parameter  int NUM_INPUTS  = 4096,
    localparam int LEVELS      = $clog2(NUM_INPUTS),
    localparam int SUM_WIDTH   = INPUT_WIDTH + LEVELS
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [NUM_INPUTS*INPUT_WIDTH-1:0]   numbers,
`ifdef TREE_ADDER_VALID_EN
    input  logic                                in_valid,
    output logic                                out_valid,
`endif
    output logic signed [SUM_WIDTH-1:0]         total_sum
);
    // Every level is packed back to back in one vector; level n starts at off(n)
    // and holds NUM_INPUTS>>n nodes of INPUT_WIDTH+n bits each.
    function automatic int off(input int n);
        int s = 0;
        for (int i = 0; i < n; i++) s += (NUM_INPUTS >> i) * (INPUT_WIDTH + i);
        return s;
    endfunction

    localparam int TOTAL = off(LEVELS + 1);

    logic [TOTAL-1:0] tree;

    assign tree[NUM_INPUTS*INPUT_WIDTH-1:0] = numbers;

    for (genvar l = 1; l <= LEVELS; l++) begin : g_lvl
        for (genvar j = 0; j < (NUM_INPUTS >> l); j++) begin : g_node
            int_adder #(.WIDTH(INPUT_WIDTH + l - 1)) u_add (
                .clk (clk),
                .rst (rst),
                .a   (tree[off(l-1) + (2*j)   * (INPUT_WIDTH+l-1) +: INPUT_WIDTH+l-1]),
                .b   (tree[off(l-1) + (2*j+1) * (INPUT_WIDTH+l-1) +: INPUT_WIDTH+l-1]),
                .sum (tree[off(l)   + j       * (INPUT_WIDTH+l)   +: INPUT_WIDTH+l])
            );
        end
    end

    assign total_sum = tree[off(LEVELS) +: SUM_WIDTH];

`ifdef TREE_ADDER_VALID_EN
    logic [LEVELS-1:0] valid_d, valid_q;
    always_comb valid_d = (valid_q << 1) | LEVELS'(in_valid);
    always_ff @(posedge clk) begin
        if (rst) valid_q <= '0;
        else     valid_q <= valid_d;
    end
    assign out_valid = valid_q[LEVELS-1];
`endif
endmodule

// File: tb/tb_tree_adder.sv
// tb_tree_adder: scoreboard bench for tree_adder at default parameters.
module tb_tree_adder;
    localparam int IW = 8;
    localparam int N  = 4096;
    localparam int L  = 12;
    localparam int SW = 20;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [N*IW-1:0]       numbers = '0;
    logic signed [SW-1:0]  total_sum;
`ifdef TREE_ADDER_VALID_EN
    logic                  in_valid = 1'b0;
    logic                  out_valid;
`endif

    int checks = 0;
    int errors = 0;
    int ops[N];
    int pos_sum;
    logic [SW:0] q[$];

    always #5 clk = ~clk;

    tree_adder dut (
        .clk       (clk),
        .rst       (rst),
        .numbers   (numbers),
`ifdef TREE_ADDER_VALID_EN
        .in_valid  (in_valid),
        .out_valid (out_valid),
`endif
        .total_sum (total_sum)
    );

    task automatic check(input string tag, input logic [SW-1:0] obs, input logic [SW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d (0x%h) expected=%0d (0x%h)", tag, $signed(obs), obs, $signed(exp), exp);
        end
    endtask

    task automatic check_valid(input string tag, input logic exp);
`ifdef TREE_ADDER_VALID_EN
        check(tag, SW'(out_valid), SW'(exp));
`endif
    endtask

    function automatic int model_sum();
        int s = 0;
        for (int i = 0; i < N; i++) s += ops[i];
        return s;
    endfunction

    // Drive ops[] for one clock, then score whatever leaves the pipeline.
    task automatic drive(input logic r, input logic v, input string tag);
        logic [SW:0] e;
        int s;
        for (int i = 0; i < N; i++) numbers[i*IW +: IW] = IW'(ops[i]);
        s = model_sum();
        rst = r;
`ifdef TREE_ADDER_VALID_EN
        in_valid = v;
`endif
        @(posedge clk);
        #1;
        if (r) begin
            q.delete();
            repeat (L - 1) q.push_back('0);
            check({tag, "_rst"}, total_sum, '0);
            check_valid({tag, "_rst_valid"}, 1'b0);
        end else begin
            q.push_back({v, SW'(s)});
            if (q.size() == L) begin
                e = q.pop_front();
                check(tag, total_sum, e[SW-1:0]);
                check_valid({tag, "_valid"}, e[SW]);
            end
        end
    endtask

    task automatic fill(input int c);
        for (int i = 0; i < N; i++) ops[i] = c;
    endtask

    initial begin
        fill(0);
        drive(1'b1, 1'b0, "reset");
        drive(1'b1, 1'b0, "reset");

        fill(-128);
        repeat (L) drive(1'b0, 1'b1, "all_min");
        check("all_min_const", total_sum, 20'h80000);

        fill(127);
        repeat (L) drive(1'b0, 1'b1, "all_max");
        check("all_max_const", total_sum, SW'(520192));

        fill(0);
        repeat (L) drive(1'b0, 1'b0, "zeros");
        fill(0);
        ops[777] = 1;
        repeat (L) drive(1'b0, 1'b1, "single_one");
        check("single_one_const", total_sum, SW'(1));

        for (int c = 0; c < 24; c++) begin
            for (int i = 0; i < N; i++) ops[i] = int'($urandom_range(255)) - 128;
            drive(1'b0, 1'($urandom_range(1)), "stream");
        end

        for (int i = 0; i < N; i++) ops[i] = int'($urandom_range(127));
        pos_sum = model_sum();
        repeat (L) drive(1'b0, 1'b1, "pos");
        check("pos_const", total_sum, SW'(pos_sum));
        for (int i = 0; i < N; i++) ops[i] = -ops[i];
        repeat (L) drive(1'b0, 1'b1, "neg");
        check("neg_const", total_sum, SW'(-pos_sum));

        fill(127);
        repeat (5) drive(1'b0, 1'b1, "pre_rst");
        drive(1'b1, 1'b1, "mid");
        repeat (L) drive(1'b0, 1'b1, "post_rst");
        check("post_rst_const", total_sum, SW'(520192));

        repeat (L) drive(1'b0, 1'b0, "drain");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/tree_adder.md
TREE_ADDER -- requirements
Module: tree_adder

Interface
REQ-001 Parameter INPUT_WIDTH, default 8, bit width of each signed two's-complement input operand; minimum 2.
REQ-002 Parameter NUM_INPUTS, default 4096, number of operands; power of two, minimum 2.
REQ-003 Derived constant LEVELS = log2(NUM_INPUTS) (12 at defaults); SUM_WIDTH = INPUT_WIDTH + LEVELS (20 at defaults).
REQ-004 One clock; reset is synchronous and active-high.
REQ-005 clk  input  1  rising-edge clock for all registers.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 numbers  input  NUM_INPUTS*INPUT_WIDTH  packed operand vector; operand k occupies bits [k*INPUT_WIDTH +: INPUT_WIDTH], signed.
REQ-008 total_sum  output  SUM_WIDTH  signed sum of all operands, driven directly from the final pipeline register.

Function
REQ-009 Block SHALL be a balanced binary pipelined adder tree of LEVELS levels built from instances of int_adder (parameter WIDTH; ports clk, rst, a, b, sum).
REQ-010 int_adder SHALL register sum = sign-extend(a) + sign-extend(b) on each rising clk edge; sum width WIDTH+1; no overflow possible.
REQ-011 Level L (1..LEVELS) SHALL hold NUM_INPUTS/2^L registers of width INPUT_WIDTH+L; node j of level L adds nodes 2j and 2j+1 of level L-1 (level 0 = operands).
REQ-012 Latency SHALL be exactly LEVELS clock edges: operands stable before edge n appear summed on total_sum after edge n+LEVELS-1 (12 edges at defaults).
REQ-013 Throughput SHALL be one new operand vector per clock; no stalls, no handshake in base configuration.
REQ-014 Result SHALL be exact: every representable input combination fits SUM_WIDTH; all -2^(INPUT_WIDTH-1) yields -2^(SUM_WIDTH-1), no wrap-around.
REQ-015 Operands SHALL be treated as signed at every level; no saturation or truncation.

Reset
REQ-016 While rst is high at a rising edge, every pipeline register in every level, and total_sum, SHALL load 0.
REQ-017 rst SHALL take priority over data; rst asserted mid-operation flushes all in-flight sums.
REQ-018 After rst deasserts, total_sum SHALL output 0 until the first post-reset operand vector has traversed LEVELS edges.

Configuration
REQ-019 Macro TREE_ADDER_VALID_EN: when defined, ports in_valid (input, 1) and out_valid (output, 1) exist; a LEVELS-deep valid shift register tracks data, out_valid high exactly when total_sum holds the sum of a vector sampled with in_valid high; valid bits reset to 0.
REQ-020 Without TREE_ADDER_VALID_EN, neither port exists; data path and latency are identical.

Verification
REQ-021 int_adder WIDTH=8: a=127, b=1 -> sum=128 (9'b010000000) one edge later.
REQ-022 int_adder WIDTH=8: a=-128, b=-1 -> sum=-129 (9'b101111111).
REQ-023 tree_adder defaults: all 4096 operands = -128 -> total_sum = -524288 (20'h80000) after 12 edges.
REQ-024 All operands = 127 -> total_sum = 520192; operands k-th = 1 for single k, else 0 -> total_sum = 1; step change shows output change exactly 12 edges later, with new vectors every cycle matching a reference model each cycle.
REQ-025 Random non-negative operands (0..127) then their negations -> sums equal in magnitude, opposite sign, matching model.
REQ-026 Assert rst for 1 cycle mid-stream with all-127 input -> total_sum = 0 next edge and stays 0 for 11 edges, then 520192; with TREE_ADDER_VALID_EN, out_valid low throughout flushed window.
